ipg_tx_packer: RTL and testbench
================================

Name: ipg_tx_packer

Overview:
- Transmit-side counterpart of the IPG request receiver.
- Accepts one memory request: header, 64-bit address, and a 512-bit payload for writes.
- Serializes the request LSB-first into variable-size inter-packet-gap slots offered each cycle by the PCS TX path.
- Drives a 64-bit IPG word plus a fill length per slot, so the far-end receiver can reassemble header, address and payload.

Parameters:
- HDR_WIDTH, 8: request header width; bit 0 = 1 write, 0 read.
- DATA_WIDTH, 64: IPG word width; bits [7:0] reserved (always zero), usable field is bits [DATA_WIDTH-1:8].
- MAX_SLOT, 56: maximum bits carried per IPG word; equals DATA_WIDTH-8.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block idle and able to accept a request.
- req_hdr  input  HDR_WIDTH  request header.
- req_addr  input  64  request address.
- req_payload  input  512  write data; ignored for reads.
- ipg_avail  input  6  bits of IPG capacity offered this cycle (0..63; values above MAX_SLOT are treated as MAX_SLOT).
- ipg_data  output  DATA_WIDTH  packed IPG word.
- ipg_len  output  6  number of valid message bits in ipg_data.
- ipg_valid  output  1  ipg_data/ipg_len carry a chunk this cycle.
- ipg_last  output  1  this chunk completes the message.
- state_reg  output  2  current FSM state, for debug.
- bits_left  output  10  message bits not yet emitted.

Behaviour:
- Message format, LSB-first: hdr[HDR_WIDTH-1:0], then addr[63:0], then payload[511:0] (write only).
  - Read length = HDR_WIDTH+64 = 72.
  - Write length = HDR_WIDTH+576 = 584.
- Storage: one 584-bit shift register plus the bits_left counter.
- Accept:
  - req_ready = 1 only in IDLE and not in reset.
  - On valid&ready, load the shift register as {payload, addr, hdr}, with payload zeroed for reads.
  - Load bits_left with 72 or 584 and go to HDR.
  - req_valid outside IDLE is ignored; the source holds it.
- Per cycle in a non-IDLE state:
  - n = min(clamp(ipg_avail,MAX_SLOT), bits_left).
  - Registered outputs, valid after the edge:
    - ipg_data[8 +: n] = shift_reg[n-1:0]; all other bits 0.
    - ipg_len = n; ipg_valid = (n != 0); ipg_last = (n == bits_left).
  - The shift register shifts right by n; bits_left decrements by n.
  - ipg_avail = 0 is a stall: ipg_valid = 0 and no state change.
- State encoding: IDLE=0, HDR=1, ADDR=2, PAYLOAD=3.
- State after each emission, from the number of bits already sent (sent):
  - sent < HDR_WIDTH → HDR.
  - sent < HDR_WIDTH+64 → ADDR.
  - otherwise → PAYLOAD.
  - A single chunk may span fields; the state reflects the field of the next unsent bit.
- On the cycle bits_left reaches 0, ipg_last = 1 and the state returns to IDLE. req_ready rises on the following cycle, so there is no same-cycle back-to-back accept.
- Latency: the first chunk can be emitted on the cycle after the accept (ipg_avail sampled in that cycle, output registered one edge later).
- When ipg_valid = 0: ipg_data = 0, ipg_len = 0, ipg_last = 0.
- Reset (async, any time, including mid-message):
  - state IDLE, bits_left 0, all outputs 0, shift register cleared.
  - The partial message is dropped; no ipg_last is emitted.
  - req_ready = 1 from the first clock after rst deasserts.

Test Plan:
- Read request, hdr=0x00, addr=0x1122334455667700, ipg_avail=56 constant → two chunks:
  - len 56, ipg_data[63:8] = {addr[47:0], hdr}.
  - then len 16, ipg_data[23:8] = addr[63:48], ipg_last=1.
  - state sequence HDR→ADDR→IDLE.
- Write request, hdr=0x01, payload=incrementing bytes, ipg_avail=56 → ten chunks of len 56 then one of len 24 with ipg_last; receiver model reconstructs hdr/addr/payload bit-exact (584 bits).
- Write with ipg_avail pattern 56,0,8,63,0,40… → ipg_valid low on zero-avail cycles; 63 clamped to 56; concatenated chunks still equal the 584-bit message.
- Boundary: ipg_avail=8 on the first chunk → chunk is exactly the header, state moves to ADDR, bits_left=64 (read).
- req_valid held during a transfer → no second accept; req_ready high the cycle after ipg_last; next request accepted then.
- rst asserted after 3 chunks of a write → outputs 0 immediately, no ipg_last; a fresh read request afterwards completes correctly in 2 chunks.

Source files
------------

// File: rtl/ipg_tx_packer_if.sv
// ipg_tx_packer_if: request intake and IPG slot bus between a request source and the packer
interface ipg_tx_packer_if #(
  parameter int HDR_WIDTH  = 8,
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic [HDR_WIDTH-1:0]  req_hdr;
  logic [63:0]           req_addr;
  logic [511:0]          req_payload;
  logic [5:0]            ipg_avail;
  logic [DATA_WIDTH-1:0] ipg_data;
  logic [5:0]            ipg_len;
  logic                  ipg_valid;
  logic                  ipg_last;
  logic [1:0]            state_reg;
  logic [9:0]            bits_left;
  modport master (
    output req_valid, req_hdr, req_addr, req_payload, ipg_avail,
    input  req_ready, ipg_data, ipg_len, ipg_valid, ipg_last, state_reg, bits_left
  );
  modport slave (
    input  req_valid, req_hdr, req_addr, req_payload, ipg_avail,
    output req_ready, ipg_data, ipg_len, ipg_valid, ipg_last, state_reg, bits_left
  );
endinterface

// File: rtl/ipg_tx_packer.sv
// ipg_tx_packer: serializes one header/address/payload request LSB-first into variable-size IPG slots
module ipg_tx_packer #(
  parameter int HDR_WIDTH  = 8,
  parameter int DATA_WIDTH = 64
) (
  input logic          clk,
  input logic          rst,
  ipg_tx_packer_if.slave bus
);
  localparam int MAX_SLOT = DATA_WIDTH - 8;
  localparam int MSG_W = HDR_WIDTH + 576;
  localparam logic [5:0] SLOT6 = 6'(MAX_SLOT);
  localparam logic [9:0] HDR_END = 10'(HDR_WIDTH);
  localparam logic [9:0] RD_LEN = 10'(HDR_WIDTH + 64);
  localparam logic [9:0] WR_LEN = 10'(MSG_W);
  typedef enum logic [1:0] {IDLE, HDR, ADDR, PAYLOAD} state_t;
  state_t                r_state;
  logic [MSG_W-1:0]      r_sr;
  logic [9:0]            r_left;
  logic                  r_wr;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data;
  logic [5:0]            r_len;
  logic                  r_valid;
  logic                  r_last;
  logic [9:0]            w_avail;
  logic [9:0]            w_n;
  logic [9:0]            w_left_nxt;
  logic [9:0]            w_sent;
  logic [MAX_SLOT-1:0]   w_mask;
  state_t                w_state_nxt;
  logic                  w_accept;
  // In IDLE bits_left is 0, so n is 0 and the emit path naturally produces an empty slot.
  always_comb begin
    w_avail = {4'd0, (bus.ipg_avail > SLOT6) ? SLOT6 : bus.ipg_avail};
    w_n = (w_avail < r_left) ? w_avail : r_left;
    w_left_nxt = r_left - w_n;
    w_sent = (r_wr ? WR_LEN : RD_LEN) - w_left_nxt;
    w_mask = ~({MAX_SLOT{1'b1}} << w_n);
    w_state_nxt = (w_left_nxt == 10'd0) ? IDLE :
                  (w_sent < HDR_END) ? HDR :
                  (w_sent < RD_LEN) ? ADDR : PAYLOAD;
    w_accept = bus.req_valid && r_ready;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_left  <= '0;
      r_wr    <= 1'b0;
      r_ready <= 1'b0;
      r_data  <= '0;
      r_len   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_ready <= (r_state == IDLE) && !w_accept;
      r_data  <= {w_mask & r_sr[MAX_SLOT-1:0], 8'd0};
      r_len   <= w_n[5:0];
      r_valid <= w_n != 10'd0;
      r_last  <= (w_n != 10'd0) && (w_n == r_left);
      if (w_accept) begin
        r_sr    <= {bus.req_hdr[0] ? bus.req_payload : 512'd0, bus.req_addr, bus.req_hdr};
        r_left  <= bus.req_hdr[0] ? WR_LEN : RD_LEN;
        r_wr    <= bus.req_hdr[0];
        r_state <= HDR;
      end else begin
        r_sr    <= r_sr >> w_n;
        r_left  <= w_left_nxt;
        r_state <= w_state_nxt;
      end
    end
  end
  assign bus.req_ready = r_ready;
  assign bus.ipg_data  = r_data;
  assign bus.ipg_len   = r_len;
  assign bus.ipg_valid = r_valid;
  assign bus.ipg_last  = r_last;
  assign bus.state_reg = r_state;
  assign bus.bits_left = r_left;
endmodule

// File: tb/tb_ipg_tx_packer.sv
// tb_ipg_tx_packer: randomized scenarios checked against a bit-position model of the serialized message
module tb_ipg_tx_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ipg_tx_packer_if bus();
  ipg_tx_packer dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_tot = 0;
  int n_bad = 0;
  logic [583:0] msg;
  logic [583:0] rx;
  int mlen, pos, chunks;
  int pat[$];
  int dflt = 56;
  function automatic int next_avail();
    if (pat.size() != 0) return pat.pop_front();
    return (dflt < 0) ? int'($urandom_range(0, 63)) : dflt;
  endfunction
  function automatic logic [511:0] rand_payload();
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[32*i +: 32] = $urandom;
    return p;
  endfunction
  task automatic send_req(input logic [7:0] hdr, input logic [63:0] addr, input logic [511:0] pl, input bit hold);
    int k = 0;
    while (bus.req_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    n_tot++;
    if (bus.req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_wait: req_ready=%b required 1", bus.req_ready);
    end
    bus.req_hdr = hdr;
    bus.req_addr = addr;
    bus.req_payload = pl;
    bus.req_valid = 1'b1;
    msg = {hdr[0] ? pl : 512'd0, addr, hdr};
    mlen = hdr[0] ? 584 : 72;
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
    n_tot++;
    if ({bus.state_reg, bus.bits_left, bus.req_ready, bus.ipg_valid} !== {2'd1, 10'(mlen), 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL accept: state=%0d left=%0d ready=%b valid=%b required state=1 left=%0d ready=0 valid=0",
               bus.state_reg, bus.bits_left, bus.req_ready, bus.ipg_valid, mlen);
    end
  endtask
  task automatic run_msg(input int stop_after);
    int cyc = 0;
    int rpos = 0;
    pos = 0;
    chunks = 0;
    rx = '0;
    while (pos < mlen && cyc < 2000 && (stop_after == 0 || cyc < stop_after)) begin
      int a, n;
      logic [63:0] ed;
      logic [1:0] es;
      a = next_avail();
      bus.ipg_avail = 6'(a);
      n = (a > 56) ? 56 : a;
      if (n > mlen - pos) n = mlen - pos;
      ed = '0;
      for (int b = 0; b < n; b++) ed[8+b] = msg[pos+b];
      @(posedge clk); #1;
      cyc++;
      pos += n;
      es = (pos == mlen) ? 2'd0 : (pos < 8) ? 2'd1 : (pos < 72) ? 2'd2 : 2'd3;
      n_tot++;
      if ({bus.ipg_valid, bus.ipg_last, bus.ipg_len, bus.ipg_data} !== {n != 0, n != 0 && pos == mlen, 6'(n), ed}) begin
        n_bad++;
        $display("FAIL chunk@%0d: valid=%b last=%b len=%0d data=%h required valid=%b last=%b len=%0d data=%h",
                 pos, bus.ipg_valid, bus.ipg_last, bus.ipg_len, bus.ipg_data, n != 0, n != 0 && pos == mlen, n, ed);
      end
      n_tot++;
      if ({bus.state_reg, bus.bits_left, bus.req_ready} !== {es, 10'(mlen - pos), 1'b0}) begin
        n_bad++;
        $display("FAIL ctrl@%0d: state=%0d left=%0d ready=%b required state=%0d left=%0d ready=0",
                 pos, bus.state_reg, bus.bits_left, bus.req_ready, es, mlen - pos);
      end
      if (bus.ipg_valid === 1'b1) begin
        chunks++;
        for (int b = 0; b < int'(bus.ipg_len); b++)
          if (rpos + b < 584) rx[rpos+b] = bus.ipg_data[8+b];
        rpos += int'(bus.ipg_len);
      end
    end
    if (stop_after == 0) begin
      n_tot++;
      if (pos != mlen) begin
        n_bad++;
        $display("FAIL timeout: sent=%0d required %0d", pos, mlen);
      end
    end
  endtask
  task automatic check_rx(input string name, input int exp_chunks);
    n_tot++;
    if (rx !== msg) begin
      n_bad++;
      $display("FAIL %s_recon: got=%h required=%h", name, rx, msg);
    end
    if (exp_chunks > 0) begin
      n_tot++;
      if (chunks != exp_chunks) begin
        n_bad++;
        $display("FAIL %s_chunks: got=%0d required=%0d", name, chunks, exp_chunks);
      end
    end
  endtask
  task automatic test_reset();
    #1;
    n_tot++;
    if ({bus.req_ready, bus.ipg_valid, bus.ipg_last, bus.ipg_len, bus.ipg_data, bus.state_reg, bus.bits_left} !== '0) begin
      n_bad++;
      $display("FAIL reset_hold: ready=%b valid=%b data=%h state=%0d left=%0d required all 0",
               bus.req_ready, bus.ipg_valid, bus.ipg_data, bus.state_reg, bus.bits_left);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_tot++;
    if ({bus.req_ready, bus.state_reg, bus.bits_left, bus.ipg_valid} !== {1'b1, 2'd0, 10'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_release: ready=%b state=%0d left=%0d valid=%b required ready=1 state=0 left=0 valid=0",
               bus.req_ready, bus.state_reg, bus.bits_left, bus.ipg_valid);
    end
  endtask
  task automatic test_read_fixed();
    dflt = 56;
    send_req(8'h00, 64'h1122334455667700, rand_payload(), 1'b0);
    run_msg(0);
    check_rx("read56", 2);
  endtask
  task automatic test_write_fixed();
    logic [511:0] pl;
    for (int i = 0; i < 64; i++) pl[8*i +: 8] = 8'(i);
    dflt = 56;
    send_req(8'h01, {$urandom, $urandom}, pl, 1'b0);
    run_msg(0);
    check_rx("write56", 11);
  endtask
  task automatic test_write_pattern();
    pat = '{56, 0, 8, 63, 0, 40};
    dflt = -1;
    send_req(8'h01 | 8'($urandom), {$urandom, $urandom}, rand_payload(), 1'b0);
    run_msg(0);
    check_rx("write_pat", 0);
  endtask
  task automatic test_hdr_boundary();
    pat = '{8};
    dflt = 56;
    send_req(8'hA4, {$urandom, $urandom}, rand_payload(), 1'b0);
    run_msg(0);
    check_rx("hdr8", 3);
  endtask
  task automatic test_back_to_back();
    dflt = -1;
    send_req(8'($urandom), {$urandom, $urandom}, rand_payload(), 1'b1);
    run_msg(0);
    @(posedge clk); #1;
    n_tot++;
    if ({bus.req_ready, bus.state_reg} !== {1'b1, 2'd0}) begin
      n_bad++;
      $display("FAIL b2b_ready: ready=%b state=%0d required ready=1 state=0", bus.req_ready, bus.state_reg);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_tot++;
    if ({bus.state_reg, bus.bits_left, bus.req_ready} !== {2'd1, 10'(mlen), 1'b0}) begin
      n_bad++;
      $display("FAIL b2b_accept: state=%0d left=%0d ready=%b required state=1 left=%0d ready=0",
               bus.state_reg, bus.bits_left, bus.req_ready, mlen);
    end
    run_msg(0);
    check_rx("b2b", 0);
  endtask
  task automatic test_random();
    dflt = -1;
    for (int t = 0; t < 6; t++) begin
      send_req(8'($urandom), {$urandom, $urandom}, rand_payload(), 1'b0);
      run_msg(0);
      check_rx("random", 0);
    end
  endtask
  task automatic test_reset_mid();
    dflt = 56;
    send_req(8'h01, {$urandom, $urandom}, rand_payload(), 1'b0);
    run_msg(3);
    #2 rst = 1'b1;
    #1;
    n_tot++;
    if ({bus.req_ready, bus.ipg_valid, bus.ipg_last, bus.ipg_len, bus.ipg_data, bus.state_reg, bus.bits_left} !== '0) begin
      n_bad++;
      $display("FAIL midreset_out: ready=%b valid=%b last=%b data=%h state=%0d left=%0d required all 0",
               bus.req_ready, bus.ipg_valid, bus.ipg_last, bus.ipg_data, bus.state_reg, bus.bits_left);
    end
    repeat (2) begin
      @(posedge clk); #1;
      n_tot++;
      if ({bus.ipg_valid, bus.ipg_last, bus.req_ready} !== 3'b000) begin
        n_bad++;
        $display("FAIL midreset_hold: valid=%b last=%b ready=%b required 0 0 0", bus.ipg_valid, bus.ipg_last, bus.req_ready);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tot++;
    if ({bus.req_ready, bus.ipg_last, bus.state_reg, bus.bits_left} !== {1'b1, 1'b0, 2'd0, 10'd0}) begin
      n_bad++;
      $display("FAIL midreset_release: ready=%b last=%b state=%0d left=%0d required ready=1 last=0 state=0 left=0",
               bus.req_ready, bus.ipg_last, bus.state_reg, bus.bits_left);
    end
    send_req(8'h00 | (8'($urandom) & 8'hFE), {$urandom, $urandom}, rand_payload(), 1'b0);
    run_msg(0);
    check_rx("after_reset", 2);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_hdr = '0;
    bus.req_addr = '0;
    bus.req_payload = '0;
    bus.ipg_avail = '0;
    test_reset();
    test_read_fixed();
    test_write_fixed();
    test_write_pattern();
    test_hdr_boundary();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
